// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back scheduler.
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;

    // Register x0 is hard-wired to zero and never written or tracked.
    localparam logic [31:0] REG_ZERO = '0;

    // Round-robin history: which requester received the most recent grant.
    typedef enum logic {LAST_ALU, LAST_LSU} wb_last_t;

    // Address width for a register file of d entries (at least one bit).
    function automatic int aw_of(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-destination scoreboard: one busy bit per register, set when an
// instruction issues and cleared when its write-back is granted.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = aw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rs1,
    input  logic [AW-1:0]    issue_rs2,
    input  logic [AW-1:0]    issue_rd,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_rd,
    output logic [DEPTH-1:0] busy,
    output logic             stall
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             set_en;

    // Hazard detection against all three operands of the presented instruction.
    always_comb begin
        stall  = issue_valid && (busy_q[issue_rs1] || busy_q[issue_rs2] || busy_q[issue_rd]);
        set_en = issue_valid && !stall && (issue_rd != AW'(REG_ZERO));
    end

    // Next busy vector: clear first so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register; reset forgets every outstanding write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of the single register-file
// write port between ALU and LSU, a registered write stage, and a sticky
// error flag for write-backs that retire to a register nobody was waiting on.
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = aw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ALU_VALID,
    output logic             ALU_READY,
    input  logic [AW-1:0]    ALU_RD,
    input  logic [WIDTH-1:0] ALU_DATA,
    input  logic             LSU_VALID,
    output logic             LSU_READY,
    input  logic [AW-1:0]    LSU_RD,
    input  logic [WIDTH-1:0] LSU_DATA,
    input  logic             ISSUE_VALID,
    input  logic [AW-1:0]    ISSUE_RS1,
    input  logic [AW-1:0]    ISSUE_RS2,
    input  logic [AW-1:0]    ISSUE_RD,
    output logic             STALL,
    output logic             REGWRITE,
    output logic [AW-1:0]    ADR_WR_REG,
    output logic [WIDTH-1:0] WR_DATA,
    output logic             WB_ERR
);

    wb_last_t         last_q, last_d;
    logic             we_q, we_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;

    logic             alu_gnt, lsu_gnt, gnt;
    logic [AW-1:0]    gnt_rd;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_wr;
    logic [DEPTH-1:0] busy;

    // Round-robin arbiter: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        alu_gnt  = ALU_VALID && (!LSU_VALID || (last_q == LAST_LSU));
        lsu_gnt  = LSU_VALID && (!ALU_VALID || (last_q == LAST_ALU));
        gnt      = alu_gnt || lsu_gnt;
        gnt_rd   = alu_gnt ? ALU_RD : LSU_RD;
        gnt_data = alu_gnt ? ALU_DATA : LSU_DATA;
        gnt_wr   = gnt && (gnt_rd != AW'(REG_ZERO));
        last_d   = last_q;
        if (alu_gnt) begin
            last_d = LAST_ALU;
        end else if (lsu_gnt) begin
            last_d = LAST_LSU;
        end
    end

    // Output stage and error flag next-state; address/data hold when idle.
    always_comb begin
        we_d   = gnt_wr;
        adr_d  = adr_q;
        data_d = data_q;
        if (gnt) begin
            adr_d  = gnt_rd;
            data_d = gnt_data;
        end
        err_d = err_q || (gnt_wr && !busy[gnt_rd]);
    end

    // State registers; reset drops any pending write and restarts arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= LAST_LSU;
            we_q   <= 1'b0;
            adr_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            adr_q  <= adr_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    wb_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (ISSUE_VALID),
        .issue_rs1   (ISSUE_RS1),
        .issue_rs2   (ISSUE_RS2),
        .issue_rd    (ISSUE_RD),
        .clr_en      (gnt_wr),
        .clr_rd      (gnt_rd),
        .busy        (busy),
        .stall       (STALL)
    );

    assign ALU_READY  = alu_gnt;
    assign LSU_READY  = lsu_gnt;
    assign REGWRITE   = we_q;
    assign ADR_WR_REG = adr_q;
    assign WR_DATA    = data_q;
    assign WB_ERR     = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a write-back scoreboard queue.
module tb_regfile_wb_sched;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             ALU_VALID, LSU_VALID, ISSUE_VALID;
    logic             ALU_READY, LSU_READY, STALL, REGWRITE, WB_ERR;
    logic [AW-1:0]    ALU_RD, LSU_RD, ISSUE_RS1, ISSUE_RS2, ISSUE_RD, ADR_WR_REG;
    logic [WIDTH-1:0] ALU_DATA, LSU_DATA, WR_DATA;

    typedef struct packed {
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fails  = 0;

    regfile_wb_sched dut (
        .clk         (clk),
        .rst         (rst),
        .ALU_VALID   (ALU_VALID),
        .ALU_READY   (ALU_READY),
        .ALU_RD      (ALU_RD),
        .ALU_DATA    (ALU_DATA),
        .LSU_VALID   (LSU_VALID),
        .LSU_READY   (LSU_READY),
        .LSU_RD      (LSU_RD),
        .LSU_DATA    (LSU_DATA),
        .ISSUE_VALID (ISSUE_VALID),
        .ISSUE_RS1   (ISSUE_RS1),
        .ISSUE_RS2   (ISSUE_RS2),
        .ISSUE_RD    (ISSUE_RD),
        .STALL       (STALL),
        .REGWRITE    (REGWRITE),
        .ADR_WR_REG  (ADR_WR_REG),
        .WR_DATA     (WR_DATA),
        .WB_ERR      (WB_ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Move to just after the next rising edge to drive new inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ALU_VALID = 0; ALU_RD = 0; ALU_DATA = 0;
        LSU_VALID = 0; LSU_RD = 0; LSU_DATA = 0;
        ISSUE_VALID = 0; ISSUE_RS1 = 0; ISSUE_RS2 = 0; ISSUE_RD = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
        ISSUE_VALID = 1; ISSUE_RS1 = rs1; ISSUE_RS2 = rs2; ISSUE_RD = rd;
    endtask

    // Monitor: every write presented by the DUT must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && REGWRITE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, ADR_WR_REG, WR_DATA}, 64'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_addr", 64'(ADR_WR_REG), 64'(e.rd));
                check("wb_data", 64'(WR_DATA), 64'(e.data));
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_regwrite", 64'(REGWRITE), 64'd0);
        check("rst_adr", 64'(ADR_WR_REG), 64'd0);
        check("rst_data", 64'(WR_DATA), 64'd0);
        check("rst_stall", 64'(STALL), 64'd0);
        check("rst_wb_err", 64'(WB_ERR), 64'd0);

        // Single ALU write to r5 after an instruction targeting r5 issued
        tick();
        issue(0, 0, 5);
        @(negedge clk);
        check("issue5_stall", 64'(STALL), 64'd0);
        tick();
        ISSUE_VALID = 0;
        ALU_VALID = 1; ALU_RD = 5; ALU_DATA = 32'hDEADBEEF;
        exp_q.push_back('{rd: 5, data: 32'hDEADBEEF});
        @(negedge clk);
        check("alu5_ready", 64'(ALU_READY), 64'd1);
        check("alu5_lsu_ready", 64'(LSU_READY), 64'd0);
        tick();
        ALU_VALID = 0;
        @(negedge clk);
        check("alu5_we", 64'(REGWRITE), 64'd1);
        tick();
        @(negedge clk);
        check("alu5_we_drop", 64'(REGWRITE), 64'd0);
        check("alu5_hold_adr", 64'(ADR_WR_REG), 64'd5);
        check("alu5_wb_err", 64'(WB_ERR), 64'd0);

        // Write to x0 handshakes but never writes
        tick();
        ALU_VALID = 1; ALU_RD = 0; ALU_DATA = 32'h1234;
        @(negedge clk);
        check("x0_ready", 64'(ALU_READY), 64'd1);
        tick();
        ALU_VALID = 0;
        @(negedge clk);
        check("x0_no_we", 64'(REGWRITE), 64'd0);
        check("x0_wb_err", 64'(WB_ERR), 64'd0);

        // RAW hazard on r7 resolved by an LSU write
        tick();
        issue(0, 0, 7);
        @(negedge clk);
        check("issue7_stall", 64'(STALL), 64'd0);
        tick();
        issue(7, 0, 8);
        @(negedge clk);
        check("raw7_stall_a", 64'(STALL), 64'd1);
        tick();
        @(negedge clk);
        check("raw7_stall_b", 64'(STALL), 64'd1);
        tick();
        LSU_VALID = 1; LSU_RD = 7; LSU_DATA = 32'hCAFE0007;
        exp_q.push_back('{rd: 7, data: 32'hCAFE0007});
        @(negedge clk);
        check("raw7_stall_n", 64'(STALL), 64'd1);
        check("raw7_lsu_ready", 64'(LSU_READY), 64'd1);
        tick();
        LSU_VALID = 0;
        @(negedge clk);
        check("raw7_stall_n1", 64'(STALL), 64'd0);
        tick();
        ISSUE_VALID = 0;
        @(negedge clk);
        check("raw7_wb_err", 64'(WB_ERR), 64'd0);
        check("raw7_idle_stall", 64'(STALL), 64'd0);

        // Write to a register with no pending writer: sticky error
        do_reset();
        ALU_VALID = 1; ALU_RD = 9; ALU_DATA = 32'h99;
        exp_q.push_back('{rd: 9, data: 32'h99});
        tick();
        ALU_VALID = 0;
        @(negedge clk);
        check("err9_set", 64'(WB_ERR), 64'd1);
        tick();
        tick();
        @(negedge clk);
        check("err9_sticky", 64'(WB_ERR), 64'd1);

        // Round-robin from reset with both requesters always valid
        do_reset();
        @(negedge clk);
        check("rr_err_cleared", 64'(WB_ERR), 64'd0);
        begin
            int a_idx = 0;
            int l_idx = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                ALU_VALID = 1; ALU_RD = 1; ALU_DATA = 32'hA000_0000 | a_idx;
                LSU_VALID = 1; LSU_RD = 2; LSU_DATA = 32'hB000_0000 | l_idx;
                if (c % 2 == 0) begin
                    exp_q.push_back('{rd: 1, data: 32'hA000_0000 | a_idx});
                end else begin
                    exp_q.push_back('{rd: 2, data: 32'hB000_0000 | l_idx});
                end
                @(negedge clk);
                check("rr_alu_ready", 64'(ALU_READY), 64'(c % 2 == 0));
                check("rr_lsu_ready", 64'(LSU_READY), 64'(c % 2 == 1));
                if (c > 0) check("rr_we_streak", 64'(REGWRITE), 64'd1);
                if (c % 2 == 0) a_idx++; else l_idx++;
            end
        end
        tick();
        idle_inputs();
        @(negedge clk);
        check("rr_we_last", 64'(REGWRITE), 64'd1);
        tick();
        @(negedge clk);
        check("rr_we_end", 64'(REGWRITE), 64'd0);

        // Reset asserted while a grant to r3 sits in the output stage
        do_reset();
        issue(0, 0, 3);
        tick();
        issue(0, 0, 4);
        tick();
        ISSUE_VALID = 0;
        ALU_VALID = 1; ALU_RD = 3; ALU_DATA = 32'h3333;
        tick();
        ALU_VALID = 0;
        rst = 1'b1;
        #1;
        check("rstmid_we", 64'(REGWRITE), 64'd0);
        check("rstmid_adr", 64'(ADR_WR_REG), 64'd0);
        ALU_VALID = 1; ALU_RD = 6; ALU_DATA = 32'h6666;
        @(negedge clk);
        check("rstmid_ready", 64'(ALU_READY), 64'd1);
        tick();
        @(negedge clk);
        check("rstmid_we_hold", 64'(REGWRITE), 64'd0);
        tick();
        rst = 1'b0;
        ALU_VALID = 0;
        issue(4, 3, 4);
        @(negedge clk);
        check("rstmid_stall", 64'(STALL), 64'd0);
        check("rstmid_err", 64'(WB_ERR), 64'd0);
        tick();
        ISSUE_VALID = 0;
        ALU_VALID = 1; ALU_RD = 10; ALU_DATA = 32'hA10;
        LSU_VALID = 1; LSU_RD = 11; LSU_DATA = 32'hB11;
        exp_q.push_back('{rd: 10, data: 32'hA10});
        @(negedge clk);
        check("post_rst_alu_ready", 64'(ALU_READY), 64'd1);
        check("post_rst_lsu_ready", 64'(LSU_READY), 64'd0);
        tick();
        idle_inputs();
        tick();
        tick();
        @(negedge clk);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and scoreboard for the 32×32 integer register file. It arbitrates the register file's single write port between the ALU result path and the load/store unit (LSU) using round-robin. It drives REGWRITE/ADR_WR_REG/WR_DATA from a registered output stage and tracks outstanding destination registers so the issue stage stalls on RAW/WAW hazards.

## Interface
- WIDTH, 32, data width of register file entries
- DEPTH, 32, number of registers; address width AW = $clog2(DEPTH)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- ALU_VALID  in  1  ALU write-back request
- ALU_READY  out  1  ALU request accepted this cycle
- ALU_RD  in  AW  ALU destination register
- ALU_DATA  in  WIDTH  ALU result
- LSU_VALID  in  1  LSU write-back request
- LSU_READY  out  1  LSU request accepted this cycle
- LSU_RD  in  AW  LSU destination register
- LSU_DATA  in  WIDTH  load data
- ISSUE_VALID  in  1  issue stage presents an instruction
- ISSUE_RS1, ISSUE_RS2, ISSUE_RD  in  AW each  source and destination registers of the presented instruction
- STALL  out  1  instruction must not issue this cycle
- REGWRITE  out  1  register-file write enable
- ADR_WR_REG  out  AW  register-file write address
- WR_DATA  out  WIDTH  register-file write data
- WB_ERR  out  1  sticky: write-back retired to a non-pending register

## Operation
- Handshake: a transfer occurs when VALID && READY. VALID must not depend on READY. RD/DATA are held stable while VALID && !READY.
- Arbiter: one state bit LAST ∈ {LAST_ALU, LAST_LSU}; reset = LAST_LSU, so the ALU wins the first tie.
  - Only one requester valid: it is granted.
  - Both valid: the requester other than LAST is granted.
  - LAST updates on every grant.
  - At most one grant per cycle.
  - READY = grant; READY is combinational from VALID and LAST.
- Output stage: on a grant, registers {we, rd, data}. we = (rd != 0). Without a grant, we = 0 next cycle; ADR_WR_REG/WR_DATA hold their last values.
- x0: requests to rd = 0 complete the handshake but never assert REGWRITE and never touch the scoreboard.
- Scoreboard: BUSY[DEPTH-1:0]; BUSY[0] is constant 0.
  - Set: ISSUE_VALID && !STALL && ISSUE_RD != 0 sets BUSY[ISSUE_RD].
  - Clear: a grant to rd != 0 clears BUSY[rd] in the same posedge that loads the output stage.
  - Set and clear of the same register in one cycle: set wins.
- STALL = ISSUE_VALID && (BUSY[ISSUE_RS1] || BUSY[ISSUE_RS2] || BUSY[ISSUE_RD]). When ISSUE_VALID = 0, STALL = 0.
- WB_ERR: set when a grant has rd != 0 and BUSY[rd] = 0. Cleared only by rst.

## Timing
- Grant in cycle N → REGWRITE/ADR_WR_REG/WR_DATA valid throughout cycle N+1. The register file (negedge write) commits mid-cycle N+1.
- BUSY[rd] is 0 from cycle N+1. A dependent instruction issues in N+1 and reads the committed value before the posedge ending N+1.
- Back-to-back grants every cycle: sustained throughput is one write per cycle.
- Fairness: a continuously valid requester is granted within 2 cycles.
- rst asserted at any time, including mid-transfer:
  - REGWRITE = 0, ADR_WR_REG = 0, WR_DATA = 0.
  - BUSY = 0, LAST = LAST_LSU, WB_ERR = 0.
  - Any write pending in the output stage is dropped.
  - READY outputs still follow VALID combinationally; grants during rst have no effect.
- First cycle after rst deassert behaves as a fresh start.

## Structure
- Shared package regfile_pkg:
  - default WIDTH/DEPTH;
  - AW derivation;
  - typedef enum logic {LAST_ALU, LAST_LSU} wb_last_t;
  - localparam REG_ZERO = '0.
- Sub-module wb_scoreboard holds BUSY, set/clear logic and STALL. The top level contains the arbiter, the output stage and WB_ERR.

## Test plan
- ALU_VALID=1, ALU_RD=5, ALU_DATA=0xDEADBEEF, LSU idle → ALU_READY=1 same cycle; next cycle REGWRITE=1, ADR_WR_REG=5, WR_DATA=0xDEADBEEF; the following cycle REGWRITE=0.
- Both valid every cycle for 6 cycles (ALU_RD=1, LSU_RD=2) from reset → grants ALU, LSU, ALU, LSU, ALU, LSU; REGWRITE high for 6 consecutive cycles with addresses 1,2,1,2,1,2.
- Issue RD=7 (STALL=0); then ISSUE_RS1=7 → STALL=1 until LSU write to 7 is granted in cycle N; STALL=0 in N+1.
- ALU request with ALU_RD=0, data 0x1234 → ALU_READY=1, REGWRITE stays 0, BUSY unchanged, WB_ERR=0.
- Grant to rd=9 with BUSY[9]=0 → WB_ERR=1 and stays 1 until rst.
- rst pulse in the cycle after a grant to rd=3 → REGWRITE=0 during reset, no write to 3; all BUSY=0, STALL=0; first tie after reset grants ALU.
